// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the stall/flush
// sequencer (slave): hazard/readiness inputs plus stage enables and flushes.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  idex_memread;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic [REG_ADDR_W-1:0] ifid_rs;
  logic [REG_ADDR_W-1:0] ifid_rt;
  logic                  ifid_uses_rt;
  logic                  branch_taken;
  logic                  hlt_id;
  logic                  imem_ready;
  logic                  exmem_memaccess;
  logic                  dmem_ready;

  logic                  pc_wen;
  logic                  ifid_wen;
  logic                  idex_wen;
  logic                  exmem_wen;
  logic                  memwb_wen;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  memwb_flush;
  logic                  halted;
  logic                  mem_err;
  logic [15:0]           stall_cnt;

  modport master (
    output idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
           branch_taken, hlt_id, imem_ready, exmem_memaccess, dmem_ready,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, memwb_flush, halted, mem_err, stall_cnt
  );

  modport slave (
    input  idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
           branch_taken, hlt_id, imem_ready, exmem_memaccess, dmem_ready,
    output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, memwb_flush, halted, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, halt drain, dmem watchdog.
// Optional stall-cycle counter built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int HALT_DRAIN   = 3,
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  ctl
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e     state_q, state_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       halted_q, halted_d;

  logic [REG_ADDR_W-1:0] rd;
  logic dmem_stall, load_use;
  logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic ifid_flush, idex_flush, memwb_flush;

  assign rd         = ctl.idex_rd;
  assign dmem_stall = ctl.exmem_memaccess & ~ctl.dmem_ready;
  assign load_use   = ctl.idex_memread & (rd != '0) &
                      ((rd == ctl.ifid_rs) | (ctl.ifid_uses_rt & (rd == ctl.ifid_rt)));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    idex_wen    = 1'b1;
    exmem_wen   = 1'b1;
    memwb_wen   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_wen = 1'b0; ifid_wen = 1'b0; idex_wen = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0;
      ifid_flush = 1'b1; idex_flush = 1'b1; memwb_flush = 1'b1;
    end else if (state_q == HALTED) begin
      pc_wen = 1'b0; ifid_wen = 1'b0; idex_wen = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0;
    end else if (dmem_stall) begin
      // Freeze everything upstream of MEM; bubble into WB. Drain count holds.
      pc_wen = 1'b0; ifid_wen = 1'b0; idex_wen = 1'b0; exmem_wen = 1'b0;
      memwb_flush = 1'b1;
    end else if (state_q == DRAIN) begin
      pc_wen     = 1'b0;
      ifid_flush = 1'b1;
      if (drain_cnt_q == 3'd0) state_d = HALTED;
      else                     drain_cnt_d = drain_cnt_q - 3'd1;
    end else if (load_use) begin
      // Branch/HLT in ID are simply re-seen next cycle once the load resolves.
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      idex_flush = 1'b1;
    end else if (ctl.branch_taken) begin
      ifid_flush = 1'b1;
    end else if (ctl.hlt_id) begin
      pc_wen      = 1'b0;
      ifid_flush  = 1'b1;
      state_d     = DRAIN;
      drain_cnt_d = 3'(HALT_DRAIN);
    end else if (!ctl.imem_ready) begin
      pc_wen     = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (dmem_stall) wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    mem_err_d = mem_err_q | (wait_cnt_q >= 8'(DMEM_TIMEOUT));
    halted_d  = (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      halted_q    <= halted_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALTED) && !pc_wen && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign ctl.stall_cnt = stall_cnt_q;
`else
  assign ctl.stall_cnt = 16'h0000;
`endif

  assign ctl.pc_wen      = pc_wen;
  assign ctl.ifid_wen    = ifid_wen;
  assign ctl.idex_wen    = idex_wen;
  assign ctl.exmem_wen   = exmem_wen;
  assign ctl.memwb_wen   = memwb_wen;
  assign ctl.ifid_flush  = ifid_flush;
  assign ctl.idex_flush  = idex_flush;
  assign ctl.memwb_flush = memwb_flush;
  assign ctl.halted      = halted_q;
  assign ctl.mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; ctl vector = {5 wens (pc..memwb), ifid/idex/memwb flush}.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_W(4)) bus ();

  pipeline_ctrl #(.REG_ADDR_W(4), .HALT_DRAIN(3), .DMEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.slave)
  );

  logic [7:0] ctl;
  assign ctl = {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen, bus.memwb_wen,
                bus.ifid_flush, bus.idex_flush, bus.memwb_flush};

  localparam logic [7:0] C_RST   = 8'b00000_111;
  localparam logic [7:0] C_RUN   = 8'b11111_000;
  localparam logic [7:0] C_LU    = 8'b00111_010;
  localparam logic [7:0] C_BR    = 8'b11111_100;
  localparam logic [7:0] C_FSTL  = 8'b01111_100;
  localparam logic [7:0] C_DMEM  = 8'b00001_001;
  localparam logic [7:0] C_HALT  = 8'b00000_000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.idex_memread = 0; bus.idex_rd = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
    bus.ifid_uses_rt = 0; bus.branch_taken = 0; bus.hlt_id = 0; bus.imem_ready = 1;
    bus.exmem_memaccess = 0; bus.dmem_ready = 1;
  endtask

  task automatic do_reset;
    rst = 1; idle();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle();
    #3;
    checks++; if (ctl !== C_RST) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", bus.mem_err); end
    checks++; if (bus.stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    tick(); rst = 0; #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL run_default got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_load_use;
    tick(); bus.idex_memread = 1; bus.idex_rd = 3; bus.ifid_rs = 3; #1;
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs got=%b exp=%b", ctl, C_LU); end
    tick(); idle(); #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_one_cycle got=%b exp=%b", ctl, C_RUN); end
    bus.idex_memread = 1; bus.idex_rd = 0; bus.ifid_rs = 0; #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_rd_zero got=%b exp=%b", ctl, C_RUN); end
    bus.idex_rd = 5; bus.ifid_rs = 2; bus.ifid_rt = 5; bus.ifid_uses_rt = 1; #1;
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL lu_rt got=%b exp=%b", ctl, C_LU); end
    bus.ifid_uses_rt = 0; #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_rt_unused got=%b exp=%b", ctl, C_RUN); end
    bus.ifid_uses_rt = 1; bus.idex_memread = 0; #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_not_load got=%b exp=%b", ctl, C_RUN); end
    idle();
  endtask

  task automatic test_branch;
    tick(); bus.branch_taken = 1; bus.imem_ready = 0; #1;
    checks++; if (ctl !== C_BR) begin failures++; $display("FAIL br_fetch_stall got=%b exp=%b", ctl, C_BR); end
    bus.idex_memread = 1; bus.idex_rd = 4; bus.ifid_rs = 4; bus.imem_ready = 1; #1;
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL br_vs_lu got=%b exp=%b", ctl, C_LU); end
    bus.branch_taken = 0; bus.hlt_id = 1; #1;
    checks++; if (ctl !== C_LU) begin failures++; $display("FAIL hlt_vs_lu got=%b exp=%b", ctl, C_LU); end
    tick(); idle(); #1;
    // HLT was masked by load-use, so state must still be RUN
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL hlt_masked_state got=%b exp=%b", ctl, C_RUN); end
    bus.imem_ready = 0; #1;
    checks++; if (ctl !== C_FSTL) begin failures++; $display("FAIL fetch_stall got=%b exp=%b", ctl, C_FSTL); end
    idle();
  endtask

  task automatic test_dmem_stall;
    tick(); bus.exmem_memaccess = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== C_DMEM) begin failures++; $display("FAIL dmem_stall_%0d got=%b exp=%b", i, ctl, C_DMEM); end
      tick();
    end
    idle(); #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL dmem_release got=%b exp=%b", ctl, C_RUN); end
    tick(); tick();
    checks++; if (bus.mem_err !== 1'b0) begin failures++; $display("FAIL dmem_short_err got=%b exp=0", bus.mem_err); end
  endtask

  task automatic test_timeout;
    bus.exmem_memaccess = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 15) begin
        checks++; if (bus.mem_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", bus.mem_err); end
      end
      tick();
    end
    checks++; if (bus.mem_err !== 1'b1) begin failures++; $display("FAIL timeout_set got=%b exp=1", bus.mem_err); end
    idle(); tick(); tick(); tick();
    checks++; if (bus.mem_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", bus.mem_err); end
  endtask

  task automatic test_halt;
    do_reset();
    bus.hlt_id = 1; #1;
    checks++; if (ctl !== C_FSTL) begin failures++; $display("FAIL hlt_accept got=%b exp=%b", ctl, C_FSTL); end
    tick(); idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (bus.halted !== (k == 4)) begin failures++; $display("FAIL halt_edge_%0d got=%b exp=%b", k, bus.halted, (k == 4)); end
      if (k < 4) begin
        checks++; if (ctl !== C_FSTL) begin failures++; $display("FAIL drain_ctl_%0d got=%b exp=%b", k, ctl, C_FSTL); end
      end
    end
    checks++; if (ctl !== C_HALT) begin failures++; $display("FAIL halted_ctl got=%b exp=%b", ctl, C_HALT); end
    bus.branch_taken = 1; bus.exmem_memaccess = 1; bus.dmem_ready = 0; tick(); tick();
    checks++; if (ctl !== C_HALT || bus.halted !== 1'b1) begin
      failures++; $display("FAIL halted_hold got=%b/%b exp=%b/1", ctl, bus.halted, C_HALT);
    end
    idle();
  endtask

  task automatic test_halt_dmem;
    do_reset();
    bus.hlt_id = 1; tick(); idle();
    for (int k = 1; k <= 6; k++) begin
      bus.exmem_memaccess = (k == 2 || k == 3);
      bus.dmem_ready      = !(k == 2 || k == 3);
      tick();
      checks++; if (bus.halted !== (k == 6)) begin failures++; $display("FAIL halt_dmem_edge_%0d got=%b exp=%b", k, bus.halted, (k == 6)); end
    end
    idle();
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    bus.hlt_id = 1; tick(); idle(); tick();
    #2 rst = 1; #1;
    checks++; if (ctl !== C_RST) begin failures++; $display("FAIL async_rst_ctl got=%b exp=%b", ctl, C_RST); end
    tick(); rst = 0; #1;
    checks++; if (ctl !== C_RUN || bus.halted !== 1'b0) begin
      failures++; $display("FAIL post_rst_run got=%b/%b exp=%b/0", ctl, bus.halted, C_RUN);
    end
    tick(); tick(); tick(); tick(); tick();
    checks++; if (bus.halted !== 1'b0 || ctl !== C_RUN) begin
      failures++; $display("FAIL post_rst_no_halt got=%b/%b exp=%b/0", ctl, bus.halted, C_RUN);
    end
  endtask

  task automatic test_stall_cnt;
    logic [15:0] exp_cnt;
`ifdef PIPE_PERF_CNT_EN
    exp_cnt = 16'd6;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    bus.imem_ready = 0;
    repeat (5) tick();
    bus.imem_ready = 1; bus.idex_memread = 1; bus.idex_rd = 7; bus.ifid_rs = 7;
    tick(); idle(); tick(); tick();
    checks++; if (bus.stall_cnt !== exp_cnt) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_dmem_stall();
    test_timeout();
    test_halt();
    test_halt_dmem();
    test_reset_mid_drain();
    test_stall_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Every cycle it computes write-enables and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Inputs are load-use hazard information, branch resolution in ID, multi-cycle instruction/data memory readiness and HLT decode. It also owns the halt-drain sequence and a data-memory timeout watchdog.

## Interface
- `REG_ADDR_W`, 4, register-specifier width
- `HALT_DRAIN`, 3, cycles the pipeline advances after HLT leaves ID before freezing (1..7)
- `DMEM_TIMEOUT`, 15, max consecutive data-memory stall cycles before `mem_err` sets (1..255)
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `idex_memread`  in  1  instruction in EX is a load
- `idex_rd`  in  REG_ADDR_W  destination of instruction in EX
- `ifid_rs`, `ifid_rt`  in  REG_ADDR_W  sources of instruction in ID
- `ifid_uses_rt`  in  1  ID instruction reads rt
- `branch_taken`  in  1  branch/jump in ID resolved taken
- `hlt_id`  in  1  HLT decoded in ID
- `imem_ready`  in  1  fetch data valid this cycle
- `exmem_memaccess`  in  1  instruction in MEM reads or writes memory
- `dmem_ready`  in  1  data memory completes this cycle
- `pc_wen`, `ifid_wen`, `idex_wen`, `exmem_wen`, `memwb_wen`  out  1  stage register enables
- `ifid_flush`, `idex_flush`, `memwb_flush`  out  1  load a bubble (all control bits 0)
- `halted`  out  1  pipeline frozen after HLT
- `mem_err`  out  1  sticky data-memory timeout
- `stall_cnt`  out  16  stall-cycle counter (see Configuration)

## Operation
- State register: RUN, DRAIN, HALTED. Reset → RUN. HALTED exits only via `rst`.
- Per-cycle conditions, highest priority first; default is all enables 1, all flushes 0:
  1. HALTED: all `*_wen` = 0, flushes = 0, `halted` = 1.
  2. Dmem stall, `exmem_memaccess & ~dmem_ready`: PC/IF/ID/ID/EX/EX/MEM enables = 0, `memwb_flush` = 1. Drain counter holds.
  3. Load-use, only in RUN: `idex_memread & idex_rd != 0 & (idex_rd == ifid_rs | (ifid_uses_rt & idex_rd == ifid_rt))`. Drives `pc_wen` = 0, `ifid_wen` = 0, `idex_flush` = 1. `branch_taken` and `hlt_id` are ignored this cycle and re-evaluated next cycle.
  4. Branch taken, only in RUN: `pc_wen` = 1 (redirect), `ifid_flush` = 1. Applies even if `~imem_ready`; the in-flight fetch is discarded.
  5. HLT, only in RUN: `pc_wen` = 0, `ifid_flush` = 1. Next state DRAIN; drain counter loads HALT_DRAIN.
  6. Fetch stall, `~imem_ready`: `pc_wen` = 0, `ifid_flush` = 1. Later stages advance.
- DRAIN: `pc_wen` = 0, `ifid_flush` = 1 every cycle. The counter decrements on each cycle without a dmem stall. When the counter reaches 0 on a decrement, the next state is HALTED. Load-use, branch and fetch stall are ignored in DRAIN.
- Watchdog: an 8-bit wait counter increments on each dmem-stall cycle and clears on any other cycle. When it reaches DMEM_TIMEOUT, `mem_err` sets at the next edge and stays set until reset. The stall itself continues.
- Counters use unsigned arithmetic. The wait counter saturates at 255.

## Timing
- All enables and flushes are combinational from inputs and state in the same cycle. No added latency.
- State, drain counter, wait counter, `mem_err`, `halted` and `stall_cnt` are registered.
- While `rst` = 1: all `*_wen` = 0, all flushes = 1, `halted` = 0, `mem_err` = 0, `stall_cnt` = 0, state = RUN, both counters = 0.
- Reset asserted mid-DRAIN or mid-stall aborts immediately, asynchronously.
- HLT accepted at edge N → `halted` = 1 from edge N+HALT_DRAIN+1, absent dmem stalls. Each dmem-stall cycle adds one cycle.

## Configuration
- Macro `PIPE_PERF_CNT_EN` controls the stall counter.
- Defined: `stall_cnt` increments on every non-reset cycle with `pc_wen` = 0 in RUN or DRAIN. It saturates at 16'hFFFF and holds in HALTED.
- Undefined: the port remains and is tied to 16'h0000, and no counter flops are built.

## Test plan
- Load-use: `idex_memread` = 1, `idex_rd` = 3, `ifid_rs` = 3 for one cycle → `pc_wen` = 0, `ifid_wen` = 0, `idex_flush` = 1 that cycle only. The same case with `idex_rd` = 0 → no stall.
- Branch with fetch stall: `branch_taken` = 1, `imem_ready` = 0 → `pc_wen` = 1, `ifid_flush` = 1. Load-use plus `branch_taken` together → load-use response, `ifid_flush` = 0.
- Dmem stall: `exmem_memaccess` = 1, `dmem_ready` = 0 for 4 cycles → upstream enables 0 and `memwb_flush` = 1 for 4 cycles, `mem_err` stays 0. Holding 16 cycles with DMEM_TIMEOUT = 15 → `mem_err` = 1 and it persists after `dmem_ready`.
- Halt: `hlt_id` pulse with HALT_DRAIN = 3 → `halted` rises 4 edges later and all enables are 0. Inserting 2 dmem-stall cycles during DRAIN → 6 edges.
- Reset mid-DRAIN: assert `rst` asynchronously → enables 0 and flushes 1 immediately. After release, state is RUN and `halted` = 0.
- `PIPE_PERF_CNT_EN` defined: 5 fetch stalls plus 1 load-use → `stall_cnt` = 6. Undefined → `stall_cnt` = 0.
